// File: rtl/hazard_stall_controller_if.sv
// Bundle of pipeline-side signals seen by the hazard/stall controller.
// The pipeline (master) drives register addresses and enables; the
// controller (slave) returns stall/flush controls, forwarding selects,
// performance counters and its FSM state for debug visibility.
// There is no valid/ready handshake here: every signal is a level that is
// sampled continuously and acted upon in the same cycle.
interface hazard_stall_controller_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic [REG_W-1:0] id_rd;
    logic             id_use_rn;
    logic             id_use_rm;
    logic             id_use_rd;
    logic             branch_taken;
    logic [REG_W-1:0] ex_rd;
    logic             ex_rf_en;
    logic             ex_load;
    logic [REG_W-1:0] mem_rd;
    logic             mem_rf_en;
    logic [REG_W-1:0] wb_rd;
    logic             wb_rf_en;
    logic             nop_sel;
    logic             pc_le;
    logic             ifid_le;
    logic             ifid_clr;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [1:0]       fwd_c;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic [1:0]       state_dbg;

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
        output branch_taken, ex_rd, ex_rf_en, ex_load,
        output mem_rd, mem_rf_en, wb_rd, wb_rf_en,
        input  nop_sel, pc_le, ifid_le, ifid_clr, fwd_a, fwd_b, fwd_c,
        input  stall_count, flush_count, state_dbg
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
        input  branch_taken, ex_rd, ex_rf_en, ex_load,
        input  mem_rd, mem_rf_en, wb_rd, wb_rf_en,
        output nop_sel, pc_le, ifid_le, ifid_clr, fwd_a, fwd_b, fwd_c,
        output stall_count, flush_count, state_dbg
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard controller for the 5-stage pipeline: operand forwarding selects,
// load-use stall and taken-branch flush sequencing, and saturating
// stall/flush performance counters. Control outputs are combinational
// from the FSM state and the current inputs; R15 is never forwarded.
module hazard_stall_controller #(
    parameter int REG_W        = 4,
    parameter int MEM_STALL    = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic                      clk,
    input logic                      reset,
    hazard_stall_controller_if.slave bus
);
    localparam logic [REG_W-1:0] PC_REG = '1;
    localparam int SEQ_MAX = (MEM_STALL > FLUSH_CYCLES) ? MEM_STALL : FLUSH_CYCLES;
    localparam int SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX + 1) : 1;
    localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] STALL_LOAD = SEQ_W'(MEM_STALL - 1);
    localparam logic [SEQ_W-1:0] FLUSH_LOAD = SEQ_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           r_state;
    logic [SEQ_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic       w_lu;
    logic       w_stall_mode;
    logic       w_flush_mode;
    logic       w_pc_le;
    logic       w_ifid_clr;
    logic       w_ex_fwd_ok;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic [1:0] w_fwd_c;

    // Youngest producer wins; a load in EX has no data yet so it cannot forward.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic             used,
        input logic [REG_W-1:0] ex_rd,
        input logic             ex_ok,
        input logic [REG_W-1:0] mem_rd,
        input logic             mem_en,
        input logic [REG_W-1:0] wb_rd,
        input logic             wb_en
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && src != PC_REG) begin
            if (ex_ok && src == ex_rd)        sel = 2'b01;
            else if (mem_en && src == mem_rd) sel = 2'b10;
            else if (wb_en && src == wb_rd)   sel = 2'b11;
        end
        return sel;
    endfunction

    assign w_ex_fwd_ok = bus.ex_rf_en && !bus.ex_load;

    assign w_lu = bus.ex_load && bus.ex_rf_en && (bus.ex_rd != PC_REG) &&
                  ((bus.id_use_rn && bus.id_rn == bus.ex_rd) ||
                   (bus.id_use_rm && bus.id_rm == bus.ex_rd) ||
                   (bus.id_use_rd && bus.id_rd == bus.ex_rd));

    // Load-use beats a branch in RUN; the branch is re-seen once ID is released.
    assign w_stall_mode = !reset &&
                          ((r_state == ST_RUN && w_lu) || r_state == ST_STALL);
    assign w_flush_mode = !reset && !w_stall_mode &&
                          ((r_state == ST_RUN && bus.branch_taken) || r_state == ST_FLUSH);

    assign w_pc_le    = !reset && !w_stall_mode;
    assign w_ifid_clr = reset || w_flush_mode;

    // Forwarding selects are independent of the FSM but held at RF during reset.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        w_fwd_c = 2'b00;
        if (!reset) begin
            w_fwd_a = fwd_sel(bus.id_rn, bus.id_use_rn, bus.ex_rd, w_ex_fwd_ok,
                              bus.mem_rd, bus.mem_rf_en, bus.wb_rd, bus.wb_rf_en);
            w_fwd_b = fwd_sel(bus.id_rm, bus.id_use_rm, bus.ex_rd, w_ex_fwd_ok,
                              bus.mem_rd, bus.mem_rf_en, bus.wb_rd, bus.wb_rf_en);
            w_fwd_c = fwd_sel(bus.id_rd, bus.id_use_rd, bus.ex_rd, w_ex_fwd_ok,
                              bus.mem_rd, bus.mem_rf_en, bus.wb_rd, bus.wb_rf_en);
        end
    end

    // Bubble sequencer: the first bubble is issued from RUN, the rest counted down.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_lu) begin
                        if (MEM_STALL > 1) begin
                            r_state <= ST_STALL;
                            r_cnt   <= STALL_LOAD;
                        end
                    end else if (bus.branch_taken) begin
                        if (FLUSH_CYCLES > 1) begin
                            r_state <= ST_FLUSH;
                            r_cnt   <= FLUSH_LOAD;
                        end
                    end
                end
                ST_STALL, ST_FLUSH: begin
                    r_cnt <= r_cnt - SEQ_ONE;
                    if (r_cnt == SEQ_ONE) r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters; they never advance while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (!w_pc_le && r_stall_count != '1) r_stall_count <= r_stall_count + CNT_ONE;
            if (w_ifid_clr && r_flush_count != '1) r_flush_count <= r_flush_count + CNT_ONE;
        end
    end

    assign bus.nop_sel     = reset || w_stall_mode || w_flush_mode;
    assign bus.pc_le       = w_pc_le;
    assign bus.ifid_le     = w_pc_le;
    assign bus.ifid_clr    = w_ifid_clr;
    assign bus.fwd_a       = w_fwd_a;
    assign bus.fwd_b       = w_fwd_b;
    assign bus.fwd_c       = w_fwd_c;
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;
    assign bus.state_dbg   = r_state;
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline hazard controller for the 5-stage ARM pipeline.
- Drives the NOP-select of the control-unit output mux, the PC and IF/ID load enables, the IF/ID clear, and the operand forwarding selects for the ID-stage operand muxes.
- Sequences multi-cycle load-use stalls and branch flushes with a small FSM.
- Keeps saturating stall/flush performance counters.

Parameters:
- REG_W, 4: register address width. The all-ones address (R15/PC) is never forwarded and never causes a hazard.
- MEM_STALL, 1: bubble cycles inserted per load-use hazard (≥1).
- FLUSH_CYCLES, 1: bubble cycles inserted per taken branch (≥1).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rn, id_rm, id_rd  in  REG_W each  source register addresses of the instruction in ID (id_rd is the store data source).
- id_use_rn, id_use_rm, id_use_rd  in  1 each  the corresponding source is actually read.
- branch_taken  in  1  branch/condition resolved taken in ID.
- ex_rd  in  REG_W  destination register in EX.
- ex_rf_en  in  1  EX instruction writes the register file.
- ex_load  in  1  EX instruction is a load.
- mem_rd  in  REG_W  destination register in MEM.
- mem_rf_en  in  1  MEM instruction writes the register file.
- wb_rd  in  REG_W  destination register in WB.
- wb_rf_en  in  1  WB instruction writes the register file.
- nop_sel  out  1  to the CU output mux; 1 = inject NOP into ID/EX.
- pc_le  out  1  PC load enable.
- ifid_le  out  1  IF/ID load enable.
- ifid_clr  out  1  IF/ID synchronous clear.
- fwd_a, fwd_b, fwd_c  out  2 each  forwarding selects for Rn/Rm/Rd: 00 = RF, 01 = EX, 10 = MEM, 11 = WB.
- stall_count  out  CNT_W  cycles with pc_le = 0.
- flush_count  out  CNT_W  cycles with ifid_clr = 1.

Behaviour:
- Control outputs are combinational from state and inputs, taking effect in the same cycle. State, down-counter (cnt) and perf counters are registered.

Forwarding (per source X ∈ a/b/c, independent of FSM state):
- A source that is unused or addresses all-ones gives 00.
- Otherwise the first match in this order wins:
  - EX match with ex_rf_en && !ex_load → 01.
  - MEM match with mem_rf_en → 10.
  - WB match with wb_rf_en → 11.
  - No match → 00.

Load-use hazard (lu):
- lu = ex_load && ex_rf_en && ex_rd != all-ones && any used ID source equals ex_rd.

FSM states: RUN, STALL, FLUSH.
- RUN, lu = 1:
  - nop_sel = 1, pc_le = 0, ifid_le = 0, ifid_clr = 0.
  - If MEM_STALL > 1: next STALL, cnt ← MEM_STALL-1. Otherwise stay RUN.
  - lu has priority: branch_taken is ignored that cycle; the branch re-evaluates when ID is released.
- RUN, lu = 0, branch_taken = 1:
  - nop_sel = 1, pc_le = 1, ifid_le = 1, ifid_clr = 1.
  - If FLUSH_CYCLES > 1: next FLUSH, cnt ← FLUSH_CYCLES-1.
- RUN, otherwise:
  - nop_sel = 0, pc_le = 1, ifid_le = 1, ifid_clr = 0.
- STALL:
  - Same outputs as RUN with lu = 1; inputs ignored.
  - cnt ← cnt-1; when cnt == 1, next RUN.
- FLUSH:
  - Same outputs as the RUN branch case; branch_taken ignored.
  - cnt ← cnt-1; when cnt == 1, next RUN.
- Total bubbles per event are exactly MEM_STALL or FLUSH_CYCLES.

Perf counters:
- Increment by 1 on each rising edge where the condition holds; saturate at all-ones with no wrap.

Reset (reset = 1):
- Outputs forced to nop_sel = 1, pc_le = 0, ifid_le = 0, ifid_clr = 1, fwd_* = 00, regardless of inputs.
- At the edge: state ← RUN, cnt ← 0, both counters ← 0.
- Reset mid-STALL or mid-FLUSH aborts the sequence; the first cycle after deassertion is in RUN.
- Counters do not count during reset.

Test Plan:
- Forwarding priority: ex_rd = mem_rd = wb_rd = 3, all rf_en = 1, ex_load = 0, id_rn = 3 used → fwd_a = 01. Drop ex_rf_en → 10. Drop mem_rf_en → 11. id_rn = 15 → 00.
- Load-use, MEM_STALL = 1: ex_load = 1, ex_rd = 5, id_rm = 5 used → one cycle nop_sel = 1, pc_le = 0. Next cycle (load in MEM) → pc_le = 1, fwd_b = 10. stall_count = 1.
- Load-use, MEM_STALL = 3: same stimulus, lu held only in the first cycle → exactly 3 consecutive stall cycles, then RUN. stall_count = 3.
- Branch, FLUSH_CYCLES = 2: branch_taken pulse → 2 cycles of ifid_clr = 1 with pc_le = 1. A second branch_taken during FLUSH is ignored. flush_count = 2.
- Simultaneous lu and branch_taken → stall wins (ifid_clr = 0). Remove lu and hold branch_taken → flush follows the next cycle.
- Reset in cycle 2 of a MEM_STALL = 3 stall → outputs take reset values. After deassertion: RUN, pc_le = 1, both counters 0. Saturation: preload near the max with CNT_W = 2 and stall 5 cycles → stall_count stays at 3.
